// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the forwarding unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush/freeze controller for hazards the forwarding unit cannot resolve,
// with a timeout on data-memory waits and saturating performance counters.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       Rs1_i,
  input  logic [4:0]       Rs2_i,
  input  logic             Rs1Used_i,
  input  logic             Rs2Used_i,
  input  logic [4:0]       EXRd_i,
  input  logic             EXMemRead_i,
  input  logic             BranchTaken_i,
  input  logic             MemReq_i,
  input  logic             MemAck_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             NoOp_o,
  output logic             Flush_o,
  output logic             Freeze_o,
  output logic             Err_o,
  output logic [CNT_W-1:0] BubbleCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o,
  output logic [CNT_W-1:0] FreezeCnt_o
);

  state_t          state_q, state_d;
  logic [TO_W-1:0] wcnt_q, wcnt_d;
  logic            err_q, err_d;
  logic            load_use, mem_hold;
  logic            bub_inc, freeze_inc;

  assign load_use = EXMemRead_i && (EXRd_i != ZERO_REG) &&
                    ((Rs1Used_i && (EXRd_i == Rs1_i)) ||
                     (Rs2Used_i && (EXRd_i == Rs2_i)));
  assign mem_hold = MemReq_i && !MemAck_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    Freeze_o    = 1'b0;
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    NoOp_o      = 1'b0;
    Flush_o     = 1'b0;

    case (state_q)
      IDLE: begin
        Freeze_o = 1'b1;
        if (start_i) begin
          state_d = RUN;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (mem_hold) begin
          Freeze_o = 1'b1;
          state_d  = MEM_WAIT;
          wcnt_d   = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemAck_i) begin
          state_d = RUN;
        end else begin
          Freeze_o = 1'b1;
          if (wcnt_q == TO_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wcnt_d = wcnt_q + TO_W'(1);
          end
        end
      end
      default: begin
        Freeze_o = 1'b1;
        state_d  = IDLE;
      end
    endcase

    // Freeze outranks load-use, which outranks a taken branch (it re-resolves next cycle).
    if (Freeze_o) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (load_use) begin
      NoOp_o = 1'b1;
    end else if (BranchTaken_i) begin
      Flush_o     = 1'b1;
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
    end else begin
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
    end
  end

  assign Err_o      = err_q;
  assign bub_inc    = !Freeze_o && load_use;
  assign freeze_inc = Freeze_o && (state_q != IDLE);

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bub_inc),
    .cnt_o (BubbleCnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (Flush_o),
    .cnt_o (FlushCnt_o)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (freeze_inc),
    .cnt_o (FreezeCnt_o)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: a default instance and a small one (CNT_W=2, TIMEOUT=3)
// share stimulus and are checked against a cycle-level behavioural model.
module tb_hazard_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i, Rs1Used_i, Rs2Used_i, EXMemRead_i, BranchTaken_i, MemReq_i, MemAck_i;
  logic [4:0] Rs1_i, Rs2_i, EXRd_i;

  logic [1:0]  pcw, ifw, noop, flush, frz, err;
  logic [31:0] bub_a, fl_a, fz_a;
  logic [1:0]  bub_b, fl_b, fz_b;

  int tests = 0;
  int fails = 0;

  // Behavioural model, index 0 = default instance, 1 = small instance
  bit     m_run [2];   // out of IDLE
  bit     m_wait[2];   // waiting on memory acknowledge
  bit     m_err [2];
  int     m_wc  [2];
  longint m_bub [2], m_fl[2], m_fz[2];
  bit     e_frz [2], e_pcw[2], e_ifw[2], e_noop[2], e_flush[2];

  always #5 clk_i = ~clk_i;

  hazard_sequencer dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rs1Used_i(Rs1Used_i), .Rs2Used_i(Rs2Used_i),
    .EXRd_i(EXRd_i), .EXMemRead_i(EXMemRead_i), .BranchTaken_i(BranchTaken_i),
    .MemReq_i(MemReq_i), .MemAck_i(MemAck_i),
    .PCWrite_o(pcw[0]), .IFIDWrite_o(ifw[0]), .NoOp_o(noop[0]), .Flush_o(flush[0]),
    .Freeze_o(frz[0]), .Err_o(err[0]),
    .BubbleCnt_o(bub_a), .FlushCnt_o(fl_a), .FreezeCnt_o(fz_a)
  );

  hazard_sequencer #(.CNT_W(2), .TIMEOUT(3)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rs1Used_i(Rs1Used_i), .Rs2Used_i(Rs2Used_i),
    .EXRd_i(EXRd_i), .EXMemRead_i(EXMemRead_i), .BranchTaken_i(BranchTaken_i),
    .MemReq_i(MemReq_i), .MemAck_i(MemAck_i),
    .PCWrite_o(pcw[1]), .IFIDWrite_o(ifw[1]), .NoOp_o(noop[1]), .Flush_o(flush[1]),
    .Freeze_o(frz[1]), .Err_o(err[1]),
    .BubbleCnt_o(bub_b), .FlushCnt_o(fl_b), .FreezeCnt_o(fz_b)
  );

  function automatic longint cnt_of(int k, int w);
    if (k == 0) begin
      if (w == 0) return longint'(bub_a);
      if (w == 1) return longint'(fl_a);
      return longint'(fz_a);
    end
    if (w == 0) return longint'(bub_b);
    if (w == 1) return longint'(fl_b);
    return longint'(fz_b);
  endfunction

  function automatic bit ref_load_use();
    return EXMemRead_i && (EXRd_i != 5'd0) &&
           ((Rs1Used_i && EXRd_i == Rs1_i) || (Rs2Used_i && EXRd_i == Rs2_i));
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_wait[k] = 0; m_err[k] = 0; m_wc[k] = 0;
      m_bub[k] = 0; m_fl[k] = 0; m_fz[k] = 0;
    end
  endfunction

  function automatic void model_eval();
    bit lu, hold;
    lu   = ref_load_use();
    hold = MemReq_i && !MemAck_i;
    for (int k = 0; k < 2; k++) begin
      e_frz[k]   = !m_run[k] || (!m_wait[k] && hold) || (m_wait[k] && !MemAck_i);
      e_noop[k]  = !e_frz[k] && lu;
      e_flush[k] = !e_frz[k] && !lu && BranchTaken_i;
      e_pcw[k]   = !e_frz[k] && !lu;
      e_ifw[k]   = e_pcw[k];
    end
  endfunction

  // Advance one clock edge, updating the model from the inputs in force at that edge.
  task automatic tick();
    longint cmax;
    int     tmo;
    model_eval();
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) begin
      cmax = (k == 0) ? 64'd4294967295 : 64'd3;
      tmo  = (k == 0) ? 255 : 3;
      if (!rst_i) continue;
      if (e_noop[k] && m_bub[k] < cmax) m_bub[k]++;
      if (e_flush[k] && m_fl[k] < cmax) m_fl[k]++;
      if (e_frz[k] && m_run[k] && m_fz[k] < cmax) m_fz[k]++;
      if (!m_run[k]) begin
        if (start_i) begin m_run[k] = 1; m_err[k] = 0; end
      end else if (!m_wait[k]) begin
        if (MemReq_i && !MemAck_i) begin m_wait[k] = 1; m_wc[k] = 1; end
      end else if (MemAck_i) begin
        m_wait[k] = 0;
      end else if (m_wc[k] == tmo) begin
        m_err[k] = 1; m_run[k] = 0; m_wait[k] = 0;
      end else begin
        m_wc[k]++;
      end
    end
    if (!rst_i) model_reset();
    #1;
  endtask

  task automatic clr_in();
    start_i = 0; Rs1_i = 5'd1; Rs2_i = 5'd2; Rs1Used_i = 0; Rs2Used_i = 0;
    EXRd_i = 5'd0; EXMemRead_i = 0; BranchTaken_i = 0; MemReq_i = 0; MemAck_i = 0;
  endtask

  task automatic test_reset();
    clr_in();
    rst_i = 0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({frz[k], pcw[k], ifw[k], noop[k], flush[k], err[k]} !== 6'b100000) begin
        fails++;
        $display("FAIL reset_flags[%0d]: got %b want 100000", k,
                 {frz[k], pcw[k], ifw[k], noop[k], flush[k], err[k]});
      end
      tests++;
      if (cnt_of(k, 0) != 0 || cnt_of(k, 1) != 0 || cnt_of(k, 2) != 0) begin
        fails++;
        $display("FAIL reset_cnts[%0d]: got %0d/%0d/%0d want 0/0/0", k,
                 cnt_of(k, 0), cnt_of(k, 1), cnt_of(k, 2));
      end
    end
    tick();
    tick();
    rst_i = 1;
    start_i = 1;
    #1;
    tests++;
    if (frz[0] !== 1'b1 || pcw[0] !== 1'b0) begin
      fails++;
      $display("FAIL idle_before_start: got frz=%b pcw=%b want frz=1 pcw=0", frz[0], pcw[0]);
    end
    tick();
    start_i = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({pcw[k], ifw[k], frz[k]} !== 3'b110) begin
        fails++;
        $display("FAIL run_after_start[%0d]: got pcw/ifw/frz=%b want 110", k,
                 {pcw[k], ifw[k], frz[k]});
      end
    end
  endtask

  task automatic test_load_use();
    EXMemRead_i = 1; EXRd_i = 5'd5; Rs2_i = 5'd5; Rs2Used_i = 1; Rs1_i = 5'd3; Rs1Used_i = 1;
    #1;
    tests++;
    if ({noop[0], pcw[0], ifw[0]} !== 3'b100) begin
      fails++;
      $display("FAIL load_use_bubble: got noop/pcw/ifw=%b want 100", {noop[0], pcw[0], ifw[0]});
    end
    tick();
    clr_in();
    #1;
    tests++;
    if (bub_a !== 32'd1) begin
      fails++;
      $display("FAIL bubble_cnt_1: got %0d want 1", bub_a);
    end
    EXMemRead_i = 1; EXRd_i = 5'd0; Rs2_i = 5'd0; Rs2Used_i = 1;
    #1;
    tests++;
    if ({noop[0], pcw[0]} !== 2'b01) begin
      fails++;
      $display("FAIL load_x0_no_bubble: got noop/pcw=%b want 01", {noop[0], pcw[0]});
    end
    tick();
    clr_in();
    #1;
    tests++;
    if (bub_a !== 32'd1) begin
      fails++;
      $display("FAIL bubble_cnt_x0: got %0d want 1", bub_a);
    end
  endtask

  task automatic test_branch_vs_load_use();
    EXMemRead_i = 1; EXRd_i = 5'd9; Rs1_i = 5'd9; Rs1Used_i = 1; BranchTaken_i = 1;
    #1;
    tests++;
    if ({flush[0], noop[0]} !== 2'b01) begin
      fails++;
      $display("FAIL branch_suppressed: got flush/noop=%b want 01", {flush[0], noop[0]});
    end
    tick();
    EXMemRead_i = 0;
    #1;
    tests++;
    if ({flush[0], pcw[0], ifw[0], noop[0]} !== 4'b1110) begin
      fails++;
      $display("FAIL branch_flush: got flush/pcw/ifw/noop=%b want 1110",
               {flush[0], pcw[0], ifw[0], noop[0]});
    end
    tick();
    clr_in();
    #1;
    tests++;
    if (fl_a !== 32'd1 || bub_a !== 32'd2) begin
      fails++;
      $display("FAIL flush_cnt: got flush=%0d bubble=%0d want 1/2", fl_a, bub_a);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      MemReq_i = 1; MemAck_i = 0;
      #1;
      tests++;
      if (frz[0] !== 1'b1) begin
        fails++;
        $display("FAIL mem_freeze cyc %0d: got %b want 1", i, frz[0]);
      end
      tick();
      tests++;
      if (err[1] !== (i == 3)) begin
        fails++;
        $display("FAIL timeout_err cyc %0d: got %b want %b", i, err[1], (i == 3));
      end
    end
    MemAck_i = 1;
    #1;
    tests++;
    if ({frz[0], pcw[0], frz[1]} !== 3'b011) begin
      fails++;
      $display("FAIL ack_cycle: got frzA/pcwA/frzB=%b want 011", {frz[0], pcw[0], frz[1]});
    end
    tick();
    clr_in();
    #1;
    tests++;
    if (fz_a !== 32'd4 || fz_b !== 2'd3 || pcw[0] !== 1'b1) begin
      fails++;
      $display("FAIL freeze_cnt: got A=%0d B=%0d pcwA=%b want 4/3/1", fz_a, fz_b, pcw[0]);
    end
    start_i = 1;
    #1;
    tick();
    start_i = 0;
    #1;
    tests++;
    if ({err[1], pcw[1], pcw[0]} !== 3'b011) begin
      fails++;
      $display("FAIL err_clear_on_start: got errB/pcwB/pcwA=%b want 011",
               {err[1], pcw[1], pcw[0]});
    end
  endtask

  task automatic test_saturation();
    EXMemRead_i = 1; EXRd_i = 5'd7; Rs1_i = 5'd7; Rs1Used_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tick();
    end
    clr_in();
    #1;
    tests++;
    if (bub_b !== 2'd3 || bub_a !== 32'd7) begin
      fails++;
      $display("FAIL bubble_saturate: got B=%0d A=%0d want 3/7", bub_b, bub_a);
    end
  endtask

  task automatic test_reset_mid_stall();
    MemReq_i = 1; MemAck_i = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tick();
    end
    tests++;
    if (err[1] !== 1'b1 || frz[0] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_stall: got errB=%b frzA=%b want 1/1", err[1], frz[0]);
    end
    #2;
    rst_i = 0;
    MemAck_i = 1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({frz[k], pcw[k], err[k]} !== 3'b100 ||
          cnt_of(k, 0) != 0 || cnt_of(k, 1) != 0 || cnt_of(k, 2) != 0) begin
        fails++;
        $display("FAIL reset_mid_stall[%0d]: got frz/pcw/err=%b cnts=%0d/%0d/%0d want 100 0/0/0",
                 k, {frz[k], pcw[k], err[k]}, cnt_of(k, 0), cnt_of(k, 1), cnt_of(k, 2));
      end
    end
    tick();
    clr_in();
    rst_i = 1;
    start_i = 1;
    #1;
    tick();
    start_i = 0;
  endtask

  task automatic test_random();
    bit [5:0] got, exp;
    for (int c = 0; c < 600; c++) begin
      start_i       = ($urandom_range(0, 3) == 0);
      Rs1_i         = 5'($urandom_range(0, 3));
      Rs2_i         = 5'($urandom_range(0, 3));
      EXRd_i        = 5'($urandom_range(0, 3));
      Rs1Used_i     = 1'($urandom_range(0, 1));
      Rs2Used_i     = 1'($urandom_range(0, 1));
      EXMemRead_i   = 1'($urandom_range(0, 1));
      BranchTaken_i = ($urandom_range(0, 2) == 0);
      MemReq_i      = ($urandom_range(0, 2) == 0);
      MemAck_i      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_i = 0;
        model_reset();
      end else begin
        rst_i = 1;
      end
      #1;
      model_eval();
      for (int k = 0; k < 2; k++) begin
        got = {pcw[k], ifw[k], noop[k], flush[k], frz[k], err[k]};
        exp = {e_pcw[k], e_ifw[k], e_noop[k], e_flush[k], e_frz[k], m_err[k]};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL rand_flags[%0d] cyc %0d: got %b want %b", k, c, got, exp);
        end
        tests++;
        if (cnt_of(k, 0) != m_bub[k] || cnt_of(k, 1) != m_fl[k] || cnt_of(k, 2) != m_fz[k]) begin
          fails++;
          $display("FAIL rand_cnts[%0d] cyc %0d: got %0d/%0d/%0d want %0d/%0d/%0d", k, c,
                   cnt_of(k, 0), cnt_of(k, 1), cnt_of(k, 2), m_bub[k], m_fl[k], m_fz[k]);
        end
      end
      tick();
    end
    rst_i = 1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
